// File: rtl/gpu_pkg.sv
// gpu_pkg: rectangle record layout and copy-stream state shared by the transmitter and the GPU receiver
package gpu_pkg;
    localparam int RECT_COUNT     = 64;
    localparam int WORDS_PER_RECT = 6;
    localparam int W_ACTIVE       = 0;
    localparam int W_X            = 1;
    localparam int W_Y            = 2;
    localparam int W_WIDTH        = 3;
    localparam int W_HEIGHT       = 4;
    localparam int W_COLOR        = 5;
    localparam int N_WORDS        = RECT_COUNT * WORDS_PER_RECT;
    typedef enum logic [1:0] {IDLE, REQ, STREAM, DRAIN} state_t;
endpackage

// File: rtl/rect_stream_tx.sv
// rect_stream_tx: per-frame gapless stream of rectangle records from data memory into the GPU
module rect_stream_tx #(
    parameter int                      RECT_COUNT     = gpu_pkg::RECT_COUNT,
    parameter int                      WORDS_PER_RECT = gpu_pkg::WORDS_PER_RECT,
    parameter int                      ADDR_WIDTH     = 13,
    parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR      = 13'h1000,
    parameter int                      CNT_WIDTH      = 9
) (
    input  logic                  pixel_clk,
    input  logic                  reset,
    input  logic                  frame_start,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [15:0]           mem_rd_data,
    output logic                  gpu_idle,
    output logic                  gpu_we,
    output logic [15:0]           gpu_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err_gnt_lost,
    output logic                  err_overrun
);
    import gpu_pkg::*;

    localparam int                   N    = RECT_COUNT * WORDS_PER_RECT;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(N - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 rd_q;
    logic [15:0]          gpu_data_q;
    logic                 gpu_idle_q, gpu_we_q, done_q, err_gnt_lost_q, err_overrun_q;
    logic                 accept;

    // a frame_start landing on the done cycle is dropped even though the FSM is already back in IDLE
    assign accept      = state_q == IDLE && frame_start && !done_q;
    assign mem_req     = state_q == REQ || state_q == STREAM;
    assign mem_rd_en   = (state_q == REQ && mem_gnt) || state_q == STREAM;
    assign mem_rd_addr = BASE_ADDR + ADDR_WIDTH'(cnt_q);
    assign busy        = state_q != IDLE;
    assign gpu_idle    = gpu_idle_q;
    assign gpu_we      = gpu_we_q;
    assign gpu_data    = gpu_data_q;
    assign done        = done_q;
    assign err_gnt_lost = err_gnt_lost_q;
    assign err_overrun  = err_overrun_q;

    // next state and word counter; word 0 is read in the grant cycle while still in REQ
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:   state_d = accept ? REQ : IDLE;
            REQ: begin
                state_d = mem_gnt ? STREAM : REQ;
                cnt_d   = mem_gnt ? cnt_q + 1'b1 : cnt_q;
            end
            STREAM: begin
                state_d = cnt_q == LAST ? DRAIN : STREAM;
                cnt_d   = cnt_q == LAST ? '0 : cnt_q + 1'b1;
            end
            DRAIN:  state_d = rd_q ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state, read-data pipeline, GPU strobes and sticky error flags
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rd_q           <= 1'b0;
            gpu_data_q     <= '0;
            gpu_idle_q     <= 1'b0;
            gpu_we_q       <= 1'b0;
            done_q         <= 1'b0;
            err_gnt_lost_q <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rd_q           <= mem_rd_en;
            gpu_data_q     <= rd_q ? mem_rd_data : 16'h0;
            gpu_idle_q     <= accept;
            gpu_we_q       <= state_q == REQ && mem_gnt;
            done_q         <= state_q == DRAIN && !rd_q;
            err_gnt_lost_q <= err_gnt_lost_q | (state_q == STREAM && !mem_gnt);
            err_overrun_q  <= err_overrun_q | (frame_start && state_q != IDLE);
        end
    end
endmodule

// File: tb/tb_rect_stream_tx.sv
// tb_rect_stream_tx: directed frames against a scoreboard of expected GPU words
module tb_rect_stream_tx;
    localparam int N = 384;
    localparam int NONE = -1000;

    logic        pixel_clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        mem_gnt = 1'b0;
    logic [15:0] mem_rd_data = 16'h0;
    logic        mem_req, mem_rd_en, gpu_idle, gpu_we, busy, done, err_gnt_lost, err_overrun;
    logic [12:0] mem_rd_addr;
    logic [15:0] gpu_data;

    int          vecs = 0;
    int          errs = 0;
    logic [15:0] sb[$];
    bit          ovr_exp = 1'b0;
    bit          gl_exp = 1'b0;

    rect_stream_tx dut (
        .pixel_clk(pixel_clk), .reset(reset), .frame_start(frame_start),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .gpu_idle(gpu_idle), .gpu_we(gpu_we), .gpu_data(gpu_data),
        .busy(busy), .done(done), .err_gnt_lost(err_gnt_lost), .err_overrun(err_overrun)
    );

    always #5 pixel_clk = ~pixel_clk;

    // data memory: word at BASE+i holds 16'h0100+i, one-cycle read latency
    always @(posedge pixel_clk) if (mem_rd_en) mem_rd_data <= 16'h0100 + 16'(mem_rd_addr - 13'h1000);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " mem_req"}, mem_req, 0);
        chk({tag, " mem_rd_en"}, mem_rd_en, 0);
        chk({tag, " mem_rd_addr"}, mem_rd_addr, 13'h1000);
        chk({tag, " gpu_idle"}, gpu_idle, 0);
        chk({tag, " gpu_we"}, gpu_we, 0);
        chk({tag, " gpu_data"}, gpu_data, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " err_gnt_lost"}, err_gnt_lost, 0);
        chk({tag, " err_overrun"}, err_overrun, 0);
    endtask

    // one frame: frame_start at r=0, grant after gwait cycles; optional overrun, grant drop, reset, done-coincident start
    task automatic frame(input int gwait, input int ovr_j, input int drop_j, input int rst_j, input bit fs_done);
        int s_rel;
        int j;
        logic [15:0] e;
        s_rel = 1 + gwait;
        for (int i = 0; i < N; i++) sb.push_back(16'h0100 + 16'(i));
        for (int r = 0; r <= s_rel + N + 3; r++) begin
            j = r - s_rel;
            @(posedge pixel_clk);
            #1;
            frame_start = (r == 0) || (j == ovr_j) || (fs_done && j == N + 2);
            mem_gnt = j >= 0 && j != drop_j;
            reset = rst_j != NONE && j == rst_j + 1;
            if (j == ovr_j) ovr_exp = 1'b1;
            if (j == drop_j) gl_exp = 1'b1;
            if (rst_j != NONE && j == rst_j + 2) begin
                frame_start = 1'b0;
                @(negedge pixel_clk);
                chk_quiet("after reset");
                sb.delete();
                ovr_exp = 1'b0;
                gl_exp = 1'b0;
                return;
            end
            @(negedge pixel_clk);
            if (r >= 1) begin
                chk("gpu_idle", gpu_idle, r == 1);
                chk("busy", busy, j < N + 2);
                chk("mem_req", mem_req, j < N);
                chk("mem_rd_en", mem_rd_en, j >= 0 && j < N);
                if (j >= 0 && j < N) chk("mem_rd_addr", mem_rd_addr, 13'h1000 + 13'(j));
                chk("gpu_we", gpu_we, j == 1);
                e = 16'h0;
                if (j >= 2 && j <= N + 1) e = sb.pop_front();
                chk("gpu_data", gpu_data, e);
                chk("done", done, j == N + 2);
            end
        end
        frame_start = 1'b0;
        chk("err_overrun", err_overrun, ovr_exp);
        chk("err_gnt_lost", err_gnt_lost, gl_exp);
        chk("scoreboard drained", sb.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk);
        chk_quiet("reset");
        @(posedge pixel_clk);
        #1 reset = 1'b0;
        @(negedge pixel_clk);
        chk_quiet("idle");
        frame(0, NONE, NONE, NONE, 1'b0);
        frame(10, NONE, NONE, NONE, 1'b1);
        frame(0, 100, NONE, NONE, 1'b0);
        frame(0, NONE, 50, NONE, 1'b0);
        frame(0, NONE, NONE, 200, 1'b0);
        frame(0, NONE, NONE, NONE, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/rect_stream_tx.md
Name: rect_stream_tx

Overview:
- Transmit side of the rectangle-copy interface into the GPU.
- On each frame_start pulse (start of vertical blank), it pulses gpu_idle to return the GPU to its wait-for-copy phase.
- It then requests the shared data-memory read port and streams RECT_COUNT x 6 words from a fixed base address into the GPU. The stream runs one word per clock, with no gaps.
- It sits between the frame timing generator, the data-memory arbiter and the GPU.

Parameters:
- RECT_COUNT, 64, number of rectangle records streamed per frame.
- WORDS_PER_RECT, 6, words per record in order: active, x, y, width, height, color.
- ADDR_WIDTH, 13, data-memory word-address width.
- BASE_ADDR, 13'h1000, word address of record 0, word 0.
- CNT_WIDTH, 9, word counter width; must satisfy 2^CNT_WIDTH >= RECT_COUNT*WORDS_PER_RECT.

Ports:
- pixel_clk  in  1  clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse at start of vertical blank
- mem_req  out  1  request for data-memory read port
- mem_gnt  in  1  grant from arbiter; must stay high while mem_req is high
- mem_rd_en  out  1  read strobe
- mem_rd_addr  out  ADDR_WIDTH  read word address
- mem_rd_data  in  16  read data, valid exactly 1 cycle after mem_rd_en
- gpu_idle  out  1  pulse: GPU leaves execute, enters wait-for-copy
- gpu_we  out  1  pulse: GPU starts copy
- gpu_data  out  16  word to GPU mem_din (registered)
- busy  out  1  high from accepted frame_start until done
- done  out  1  one-cycle pulse after last word is presented
- err_gnt_lost  out  1  sticky: mem_gnt dropped during streaming
- err_overrun  out  1  sticky: frame_start arrived while busy

Behaviour:
- Reset values:
  - All outputs are 0: mem_req, mem_rd_en, gpu_idle, gpu_we, done, busy, both error flags, gpu_data=16'h0, mem_rd_addr=BASE_ADDR.
  - State is IDLE and the counter is 0.
  - A reset mid-stream aborts immediately, with no done pulse. The GPU is reset on the same reset.
- Constant: N = RECT_COUNT*WORDS_PER_RECT = 384.
- State IDLE:
  - On frame_start, assert gpu_idle for exactly 1 cycle (the next cycle) and go to REQ. busy goes high in that same cycle.
- State REQ:
  - mem_req=1; wait for mem_gnt.
  - In the first cycle with mem_gnt=1 (call it cycle S), go to STREAM.
- State STREAM:
  - Cycles S..S+N-1: mem_rd_en=1 and mem_rd_addr=BASE_ADDR+k at cycle S+k.
  - gpu_we=1 only in cycle S+1.
  - gpu_data <= mem_rd_data registered, so word k is on gpu_data during cycle S+k+2. Word 0 is therefore present the cycle after the GPU samples we.
  - gpu_data is forced to 0 outside cycles S+2..S+N+1.
  - Counter k increments modulo-free from 0 to N-1. mem_rd_en drops after k=N-1 and mem_req drops at cycle S+N.
  - Go to DRAIN.
- State DRAIN:
  - Hold until the last word has been presented (cycle S+N+1).
  - Then done=1 in cycle S+N+2, busy=0 in the same cycle, and return to IDLE.
- Total latency: frame_start to done = 3 + (grant wait) + N cycles. With mem_gnt already high the sequence is:
  - frame_start at T;
  - gpu_idle at T+1;
  - REQ at T+1, S=T+1;
  - done at T+N+3.
- No stall: the GPU cannot back-pressure, so streaming never pauses.
  - If mem_gnt=0 in any cycle S..S+N-1, set err_gnt_lost (sticky until reset) and keep streaming; the data is undefined.
- frame_start while busy: ignored; set err_overrun (sticky).
- frame_start coincident with the done cycle: ignored. Another frame_start is accepted only in IDLE.
- Address arithmetic: BASE_ADDR+k is truncated to ADDR_WIDTH (wraps). The configuration must keep BASE_ADDR+N-1 within range.
- Inactive records: words are streamed verbatim; the GPU masks inactive records.

Decomposition:
- Shared package gpu_pkg:
  - RECT_COUNT, WORDS_PER_RECT, word-order constants (W_ACTIVE=0 .. W_COLOR=5);
  - the N derivation;
  - state enum {IDLE, REQ, STREAM, DRAIN}.
- These constants are also used by the GPU receiver.
- No sub-module; the counter and FSM are single-block.

Test Plan:
- Reset then frame_start with mem_gnt=1, memory preloaded with word i = 16'h0100+i:
  - gpu_idle at T+1;
  - gpu_we at T+2;
  - gpu_data = 16'h0100+k at T+3+k for k=0..383;
  - done at T+387.
- mem_gnt held low 10 cycles after REQ: mem_rd_en first rises exactly when mem_gnt rises; gpu_we one cycle later; no words skipped.
- Second frame_start at stream word 100: ignored, err_overrun=1, stream completes unchanged.
- mem_gnt dropped for 1 cycle at k=50: err_gnt_lost=1 and stays 1; done still pulses at the nominal cycle.
- reset asserted at k=200: next cycle all outputs 0, state IDLE; a subsequent frame_start runs a full clean stream.
- Connected to the GPU with record 0 = {1, 10, 20, 5, 5, 16'h07E0}, others inactive:
  - after done, pixel (12,22) yields color 16'h07E0 after the GPU latency;
  - pixel (0,0) yields the default color.
